// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Purpose:
//   Serves single-word instruction-cache refills from a backing memory. The
//   memory uses a split protocol: an address phase (ext_req/ext_ready),
//   followed by a data phase (ext_rvalid/ext_rdata). If no data arrives within
//   TIMEOUT cycles, the same word-aligned address is re-issued and the sticky
//   timeout_err flag is raised.
//
// Parameters:
//   ADDR_WIDTH  address width
//   DATA_WIDTH  instruction word width
//   TIMEOUT     data-phase cycles without ext_rvalid before re-issue (>= 1)
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous, active-high reset
//   mem_req          refill request from the instruction cache
//   mem_addr         refill address from the cache
//   mem_instr        registered refill word returned to the cache
//   mem_instr_valid  one-cycle strobe marking a delivered refill word
//   ext_req          address-phase request to the backing memory
//   ext_addr         word-aligned address presented to the backing memory
//   ext_ready        memory accepts the address when high together with ext_req
//   ext_rdata        memory read data
//   ext_rvalid       ext_rdata is valid this cycle
//   busy             high whenever the controller is not idle
//   timeout_err      sticky timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_instr,
    output logic                  mem_instr_valid,
    output logic                  ext_req,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic                  ext_ready,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    input  logic                  ext_rvalid,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // The timeout fires in the cycle whose increment would reach TIMEOUT, so
    // a DATA cycle that sees cnt == CNT_LAST without ext_rvalid is the last one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_instr   <= '0;
            ext_addr    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        ext_addr <= mem_addr & WORD_MASK;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    // Data arriving alongside the address handshake is not ours.
                    if (ext_ready) begin
                        cnt   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Data wins over a timeout landing in the same cycle.
                    if (ext_rvalid) begin
                        mem_instr <= ext_rdata;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        // Saturate rather than wrap; ADDR clears it on accept.
                        cnt         <= CNT_MAX;
                        timeout_err <= 1'b1;
                        state       <= ADDR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // Wait for the cache to drop its request so one request
                    // never triggers two refills.
                    if (!mem_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ext_req         = (state == ADDR);
    assign mem_instr_valid = (state == RESP);
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Purpose:
//   Self-checking bench for icache_refill_ctrl (TIMEOUT overridden to 4).
//   A transaction-level reference describes each refill by its address,
//   back-pressure length, number of timeouts, data delay, data word and hold
//   length; expected outputs follow arithmetically from those numbers.
// ---------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        mem_instr_valid;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic        ext_ready;
    logic [31:0] ext_rdata;
    logic        ext_rvalid;
    logic        busy;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last delivered word and sticky error flag.
    logic [31:0] exp_instr = 32'h0;
    logic        exp_terr  = 1'b0;

    icache_refill_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .mem_instr_valid(mem_instr_valid),
        .ext_req        (ext_req),
        .ext_addr       (ext_addr),
        .ext_ready      (ext_ready),
        .ext_rdata      (ext_rdata),
        .ext_rvalid     (ext_rvalid),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete refill starting from IDLE.
    //   rd  : cycles ext_ready is held low in each address phase
    //   nto : number of data-phase timeouts before data arrives
    //   vd  : silent data-phase cycles before ext_rvalid (0 .. TO-1)
    //   h   : extra HOLD cycles with mem_req still high
    task automatic refill(input logic [31:0] a, input int rd, input int nto,
                          input int vd, input logic [31:0] d, input int h);
        logic [31:0] ea;
        int          silent;
        ea = a & 32'hFFFF_FFFC;
        chk("idle_busy", busy, 32'd0);
        chk("idle_ext_req", ext_req, 32'd0);
        mem_req  = 1'b1;
        mem_addr = a;
        tick();
        mem_addr = $urandom;
        for (int k = 0; k <= nto; k++) begin
            for (int i = 0; i < rd; i++) begin
                ext_ready  = 1'b0;
                ext_rvalid = 1'($urandom_range(0, 1));
                ext_rdata  = $urandom;
                chk("addr_wait_req", ext_req, 32'd1);
                chk("addr_wait_addr", ext_addr, ea);
                chk("addr_wait_vld", mem_instr_valid, 32'd0);
                tick();
            end
            ext_ready  = 1'b1;
            ext_rvalid = 1'b1;
            ext_rdata  = $urandom;
            chk("addr_req", ext_req, 32'd1);
            chk("addr_addr", ext_addr, ea);
            chk("addr_terr", timeout_err, {31'd0, exp_terr});
            tick();
            ext_ready  = 1'b0;
            ext_rvalid = 1'b0;
            silent = (k < nto) ? TO : vd;
            for (int j = 0; j < silent; j++) begin
                chk("data_req", ext_req, 32'd0);
                chk("data_addr", ext_addr, ea);
                chk("data_vld", mem_instr_valid, 32'd0);
                chk("data_busy", busy, 32'd1);
                tick();
            end
            if (k < nto) exp_terr = 1'b1;
        end
        ext_rvalid = 1'b1;
        ext_rdata  = d;
        chk("pre_instr", mem_instr, exp_instr);
        chk("pre_vld", mem_instr_valid, 32'd0);
        tick();
        exp_instr  = d;
        ext_rvalid = 1'b1;
        ext_rdata  = ~d;
        chk("resp_vld", mem_instr_valid, 32'd1);
        chk("resp_instr", mem_instr, exp_instr);
        chk("resp_terr", timeout_err, {31'd0, exp_terr});
        chk("resp_req", ext_req, 32'd0);
        tick();
        ext_rvalid = 1'b0;
        mem_addr   = $urandom;
        for (int i = 0; i < h; i++) begin
            chk("hold_req", ext_req, 32'd0);
            chk("hold_vld", mem_instr_valid, 32'd0);
            chk("hold_busy", busy, 32'd1);
            chk("hold_instr", mem_instr, exp_instr);
            tick();
        end
        mem_req = 1'b0;
        chk("hold_last_busy", busy, 32'd1);
        chk("hold_last_vld", mem_instr_valid, 32'd0);
        tick();
        chk("done_busy", busy, 32'd0);
        chk("done_req", ext_req, 32'd0);
        chk("done_instr", mem_instr, exp_instr);
        chk("done_terr", timeout_err, {31'd0, exp_terr});
    endtask

    initial begin
        rst        = 1'b1;
        mem_req    = 1'b0;
        mem_addr   = 32'h0;
        ext_ready  = 1'b0;
        ext_rdata  = 32'h0;
        ext_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 32'd0);
        chk("rst_ext_req", ext_req, 32'd0);
        chk("rst_ext_addr", ext_addr, 32'd0);
        chk("rst_instr", mem_instr, 32'd0);
        chk("rst_vld", mem_instr_valid, 32'd0);
        chk("rst_terr", timeout_err, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 32'd0);

        // Basic refill.
        refill(32'h0000_1007, 0, 0, 2, 32'hDEAD_BEEF, 0);

        // Spurious data while idle.
        ext_rvalid = 1'b1;
        ext_rdata  = 32'hFFFF_FFFF;
        tick();
        ext_rvalid = 1'b0;
        chk("spur_instr", mem_instr, exp_instr);
        chk("spur_vld", mem_instr_valid, 32'd0);
        chk("spur_busy", busy, 32'd0);

        // Back-pressure of 5 cycles.
        refill(32'h0000_3ABC, 5, 0, 1, 32'hA5A5_0F0F, 0);

        // Data on the last permissible cycle is taken, no timeout.
        refill(32'h0000_4000, 0, 0, TO - 1, 32'h0BAD_F00D, 0);
        chk("edge_no_terr", timeout_err, 32'd0);

        // One timeout, then normal delivery; flag stays set.
        refill(32'h0000_5002, 0, 1, 1, 32'h1234_5678, 0);
        chk("to_terr_sticky", timeout_err, 32'd1);

        // Long hold, then a second request.
        refill(32'h0000_6000, 0, 0, 0, 32'h600D_CAFE, 3);
        refill(32'h0000_2000, 1, 0, 0, 32'h2000_2000, 0);

        // Reset mid-DATA abandons the refill.
        mem_req  = 1'b1;
        mem_addr = 32'h0000_7777;
        tick();
        ext_ready = 1'b1;
        tick();
        ext_ready = 1'b0;
        mem_req   = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        exp_instr = 32'h0;
        exp_terr  = 1'b0;
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_instr", mem_instr, 32'd0);
        chk("mid_rst_terr", timeout_err, 32'd0);
        chk("mid_rst_addr", ext_addr, 32'd0);
        ext_rvalid = 1'b1;
        ext_rdata  = $urandom;
        tick();
        ext_rvalid = 1'b0;
        chk("late_vld", mem_instr_valid, 32'd0);
        chk("late_instr", mem_instr, 32'd0);
        chk("late_busy", busy, 32'd0);

        // Randomized refills against the transaction-level reference.
        for (int t = 0; t < 25; t++) begin
            refill($urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   $urandom_range(0, TO - 1), $urandom, $urandom_range(0, 2));
            ext_rvalid = 1'b1;
            ext_rdata  = $urandom;
            tick();
            ext_rvalid = 1'b0;
            chk("rnd_spur_instr", mem_instr, exp_instr);
            chk("rnd_spur_vld", mem_instr_valid, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
